// File: rtl/elevator_button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator button conditioner slice:
//   NUM_FLOORS              - number of served floors (floors are numbered 1..8)
//   DEBOUNCE_CYCLES_DEFAULT - default debounce length in synchronized clocks
//   floor_t                 - one-hot (ideally) floor vector, bit n = floor n
//   db_state_e              - debounced state of a single button
//   lamp_clear_mask()       - per-floor lamp clear mask from floor/door_open
// -----------------------------------------------------------------------------
package elevator_pkg;

    localparam int NUM_FLOORS              = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Bit n refers to floor n; bit 0 does not exist on purpose.
    typedef logic [NUM_FLOORS:1] floor_t;

    // Debounced level of one button.
    typedef enum logic [0:0] {
        DB_RELEASED = 1'b0,
        DB_PRESSED  = 1'b1
    } db_state_e;

    // Lamps are cleared at every floor position whose bit is set while the
    // door is open. A malformed (zero or multi-hot) floor vector is not
    // filtered: each set bit simply clears its own position.
    function automatic floor_t lamp_clear_mask(input floor_t floor_vec,
                                               input logic   door_open);
        floor_t mask;
        if (door_open) begin
            mask = floor_vec;
        end else begin
            mask = '0;
        end
        return mask;
    endfunction

endpackage : elevator_pkg

// File: rtl/elevator_button_conditioner_if.sv
// -----------------------------------------------------------------------------
// elevator_button_conditioner_if
// Bundles the button, floor and lamp signals between the panel/controller side
// (master) and the conditioner (slave).
//   btup_raw[7:1]        raw hall up-call buttons (asynchronous)
//   btdn_raw[8:2]        raw hall down-call buttons (asynchronous)
//   in_bt_floor_raw[8:1] raw in-car floor buttons (asynchronous)
//   floor[8:1]           current floor, one-hot, from the controller
//   door_open            door open indication from the controller
//   btup/btdn/in_bt_floor one-cycle press pulses to the controller
//   lamp_up/lamp_dn/lamp_car latched call-acknowledge lamps
// -----------------------------------------------------------------------------
interface elevator_button_conditioner_if ();
    import elevator_pkg::*;

    logic [7:1] btup_raw;
    logic [8:2] btdn_raw;
    floor_t     in_bt_floor_raw;
    floor_t     floor;
    logic       door_open;

    logic [7:1] btup;
    logic [8:2] btdn;
    floor_t     in_bt_floor;
    logic [7:1] lamp_up;
    logic [8:2] lamp_dn;
    floor_t     lamp_car;

    // Panel / controller side: drives buttons and floor state, sees results.
    modport master (
        output btup_raw, btdn_raw, in_bt_floor_raw, floor, door_open,
        input  btup, btdn, in_bt_floor, lamp_up, lamp_dn, lamp_car
    );

    // Conditioner side.
    modport slave (
        input  btup_raw, btdn_raw, in_bt_floor_raw, floor, door_open,
        output btup, btdn, in_bt_floor, lamp_up, lamp_dn, lamp_car
    );

endinterface : elevator_button_conditioner_if

// File: rtl/elevator_button_conditioner_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// One button channel: 2-flop synchronizer, debounce counter, debounced state
// and a registered one-cycle press pulse.
//   clk   system clock
//   rst   asynchronous active-low reset
//   raw   raw button level, asynchronous to clk
//   pulse registered press pulse, high for one cycle after a debounced 0->1
//   rise  combinational "debounced state goes 0->1 on the coming edge"; lets
//         the parent update its lamp on the same edge the pulse is registered
// The counter is held at 0 while the synchronized level agrees with the
// debounced state, so it never needs to count beyond DEBOUNCE_CYCLES-1.
// -----------------------------------------------------------------------------
module button_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic rise
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_r;
    logic          sync_r;
    db_state_e     db_r;
    logic [CW-1:0] cnt_r;
    logic          pulse_r;

    logic          differ_s;
    logic          settle_s;
    logic          rise_s;

    // Decode whether the synchronized level disagrees and is about to settle.
    always_comb begin
        differ_s = 1'b0;
        settle_s = 1'b0;
        rise_s   = 1'b0;
        if (db_state_e'(sync_r) != db_r) begin
            differ_s = 1'b1;
            if (cnt_r == CNT_MAX) begin
                settle_s = 1'b1;
                rise_s   = sync_r;
            end else begin
                settle_s = 1'b0;
                rise_s   = 1'b0;
            end
        end else begin
            differ_s = 1'b0;
        end
    end

    // Two-flop synchronizer; only sync_r is used by the logic below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

    // Debounce counter and debounced state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_r  <= DB_RELEASED;
            cnt_r <= '0;
        end else if (!differ_s) begin
            cnt_r <= '0;
        end else if (settle_s) begin
            db_r  <= db_state_e'(sync_r);
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Press pulse: registered on the edge the debounced state rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= rise_s;
        end
    end

    assign pulse = pulse_r;
    assign rise  = rise_s;

endmodule : button_debounce

// File: rtl/elevator_button_conditioner.sv
// -----------------------------------------------------------------------------
// elevator_button_conditioner
// Conditions the 22 elevator buttons (7 hall up, 7 hall down, 8 in-car) into
// clean one-cycle press pulses and keeps a latched acknowledge lamp per call.
//   clk  system clock, all state on posedge
//   rst  asynchronous active-low reset
//   bus  slave side of elevator_button_conditioner_if (raw buttons, floor,
//        door_open in; press pulses and lamps out)
// A lamp sets on the edge its press pulse is registered and clears while the
// door is open at its floor; a clear wins over a coincident set, but the press
// pulse still goes out so the controller sees the call.
// -----------------------------------------------------------------------------
module elevator_button_conditioner
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    elevator_button_conditioner_if.slave  bus
);

    logic [7:1] up_pulse_s;
    logic [7:1] up_rise_s;
    logic [8:2] dn_pulse_s;
    logic [8:2] dn_rise_s;
    floor_t     car_pulse_s;
    floor_t     car_rise_s;

    floor_t     clr_s;

    logic [7:1] lamp_up_r;
    logic [8:2] lamp_dn_r;
    floor_t     lamp_car_r;

    // Hall up-call channels, floors 1..7.
    for (genvar i = 1; i <= 7; i++) begin : g_up
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.btup_raw[i]),
            .pulse (up_pulse_s[i]),
            .rise  (up_rise_s[i])
        );
    end

    // Hall down-call channels, floors 2..8.
    for (genvar i = 2; i <= 8; i++) begin : g_dn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.btdn_raw[i]),
            .pulse (dn_pulse_s[i]),
            .rise  (dn_rise_s[i])
        );
    end

    // In-car floor channels, floors 1..8.
    for (genvar i = 1; i <= 8; i++) begin : g_car
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (bus.in_bt_floor_raw[i]),
            .pulse (car_pulse_s[i]),
            .rise  (car_rise_s[i])
        );
    end

    // Per-floor lamp clear request from the controller's floor/door state.
    always_comb begin
        clr_s = lamp_clear_mask(bus.floor, bus.door_open);
    end

    // Lamp latches: set by a rising debounced press, clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lamp_up_r  <= '0;
            lamp_dn_r  <= '0;
            lamp_car_r <= '0;
        end else begin
            lamp_up_r  <= (lamp_up_r  | up_rise_s)  & ~clr_s[7:1];
            lamp_dn_r  <= (lamp_dn_r  | dn_rise_s)  & ~clr_s[8:2];
            lamp_car_r <= (lamp_car_r | car_rise_s) & ~clr_s[8:1];
        end
    end

    assign bus.btup        = up_pulse_s;
    assign bus.btdn        = dn_pulse_s;
    assign bus.in_bt_floor = car_pulse_s;
    assign bus.lamp_up     = lamp_up_r;
    assign bus.lamp_dn     = lamp_dn_r;
    assign bus.lamp_car    = lamp_car_r;

endmodule : elevator_button_conditioner

// File: tb/tb_elevator_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_elevator_button_conditioner
// Directed scenarios followed by randomized button/floor/door traffic, checked
// against a behavioural model: each button's synchronized level is the raw
// level seen two edges earlier, the debounced level flips once that level has
// disagreed for DEB consecutive edges, a flip to 1 is a press, and a lamp
// remembers presses until the door opens at its floor.
// -----------------------------------------------------------------------------
module tb_elevator_button_conditioner;
    import elevator_pkg::*;

    localparam int DEB = 4;
    localparam int NB  = 22;

    logic clk = 1'b0;
    logic rst = 1'b0;

    elevator_button_conditioner_if bif ();

    elevator_button_conditioner #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state, buttons numbered 0..6 up, 7..13 down, 14..21 in-car.
    logic [NB-1:0] m_s1;
    logic [NB-1:0] m_s2;
    logic [NB-1:0] m_db;
    logic [NB-1:0] m_pulse;
    logic [NB-1:0] m_lamp;
    int            m_run [NB];

    function automatic int fl_of(input int k);
        if (k < 7)       return k + 1;
        else if (k < 14) return k - 7 + 2;
        else             return k - 14 + 1;
    endfunction

    function automatic logic raw_bit(input int k);
        if (k < 7)       return bif.btup_raw[fl_of(k)];
        else if (k < 14) return bif.btdn_raw[fl_of(k)];
        else             return bif.in_bt_floor_raw[fl_of(k)];
    endfunction

    task automatic set_raw(input int k, input logic v);
        if (k < 7)       bif.btup_raw[fl_of(k)] = v;
        else if (k < 14) bif.btdn_raw[fl_of(k)] = v;
        else             bif.in_bt_floor_raw[fl_of(k)] = v;
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_pulse = '0; m_lamp = '0;
        for (int k = 0; k < NB; k++) m_run[k] = 0;
    endtask

    task automatic model_edge(input logic [NB-1:0] rin, input floor_t f, input logic d);
        for (int k = 0; k < NB; k++) begin
            logic sync;
            sync = m_s2[k];
            m_s2[k] = m_s1[k];
            m_s1[k] = rin[k];
            m_pulse[k] = 1'b0;
            if (sync != m_db[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_db[k] = sync;
                    m_run[k] = 0;
                    m_pulse[k] = sync;
                end
            end else begin
                m_run[k] = 0;
            end
            if (d && f[fl_of(k)]) m_lamp[k] = 1'b0;
            else                  m_lamp[k] = m_lamp[k] | m_pulse[k];
        end
    endtask

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [8:0] eu, ed, ec, lu, ld, lc;
        eu = '0; ed = '0; ec = '0; lu = '0; ld = '0; lc = '0;
        for (int k = 0; k < NB; k++) begin
            if (k < 7) begin
                eu[fl_of(k)] = m_pulse[k]; lu[fl_of(k)] = m_lamp[k];
            end else if (k < 14) begin
                ed[fl_of(k)] = m_pulse[k]; ld[fl_of(k)] = m_lamp[k];
            end else begin
                ec[fl_of(k)] = m_pulse[k]; lc[fl_of(k)] = m_lamp[k];
            end
        end
        check("btup",        {1'b0, bif.btup, 1'b0},        eu);
        check("btdn",        {bif.btdn, 2'b00},             ed);
        check("in_bt_floor", {bif.in_bt_floor, 1'b0},       ec);
        check("lamp_up",     {1'b0, bif.lamp_up, 1'b0},     lu);
        check("lamp_dn",     {bif.lamp_dn, 2'b00},          ld);
        check("lamp_car",    {bif.lamp_car, 1'b0},          lc);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_btup"},  {1'b0, bif.btup, 1'b0},    9'd0);
        check({tag, "_btdn"},  {bif.btdn, 2'b00},         9'd0);
        check({tag, "_car"},   {bif.in_bt_floor, 1'b0},   9'd0);
        check({tag, "_lup"},   {1'b0, bif.lamp_up, 1'b0}, 9'd0);
        check({tag, "_ldn"},   {bif.lamp_dn, 2'b00},      9'd0);
        check({tag, "_lcar"},  {bif.lamp_car, 1'b0},      9'd0);
    endtask

    // One clock: capture inputs, advance model on the edge, compare at +1.
    task automatic step();
        logic [NB-1:0] rin;
        floor_t        f;
        logic          d;
        logic          rs;
        for (int k = 0; k < NB; k++) rin[k] = raw_bit(k);
        f  = bif.floor;
        d  = bif.door_open;
        rs = rst;
        @(posedge clk);
        if (!rs) model_reset();
        else     model_edge(rin, f, d);
        #1;
        check_all();
    endtask

    initial begin
        bif.btup_raw        = '0;
        bif.btdn_raw        = '0;
        bif.in_bt_floor_raw = '0;
        bif.floor           = '0;
        bif.door_open       = 1'b0;
        model_reset();

        // Reset state.
        step();
        step();
        check_quiet("reset");
        rst = 1'b1;

        // In-car 5 held: one pulse exactly DEB+1 edges after the first edge.
        set_raw(14 + 4, 1'b1);
        for (int s = 1; s <= 9; s++) begin
            step();
            check("car5_pulse", 9'(bif.in_bt_floor[5]), 9'((s == DEB + 2) ? 1 : 0));
        end
        check("car5_lamp", 9'(bif.lamp_car[5]), 9'd1);
        set_raw(14 + 4, 1'b0);
        for (int s = 0; s < DEB + 3; s++) step();
        check("car5_release", 9'(bif.in_bt_floor[5]), 9'd0);

        // Up 3 glitch of 3 clocks: nothing happens.
        set_raw(2, 1'b1);
        for (int s = 0; s < 3; s++) step();
        set_raw(2, 1'b0);
        for (int s = 0; s < 8; s++) begin
            step();
            check("up3_glitch", {1'b0, bif.btup, 1'b0}, 9'd0);
        end
        check("up3_lamp", {1'b0, bif.lamp_up, 1'b0}, 9'd0);

        // Light all three lamps at floor 6, then open the door there.
        set_raw(5, 1'b1); set_raw(7 + 4, 1'b1); set_raw(14 + 5, 1'b1);
        for (int s = 0; s < DEB + 2; s++) step();
        set_raw(5, 1'b0); set_raw(7 + 4, 1'b0); set_raw(14 + 5, 1'b0);
        for (int s = 0; s < DEB + 3; s++) step();
        check("f6_lamps_lit", 9'({bif.lamp_up[6], bif.lamp_dn[6], bif.lamp_car[6]}), 9'd7);
        bif.floor = 8'b0010_0000;
        bif.door_open = 1'b1;
        step();
        check("f6_lamps_clr", 9'({bif.lamp_up[6], bif.lamp_dn[6], bif.lamp_car[6]}), 9'd0);
        check("car5_kept", 9'(bif.lamp_car[5]), 9'd1);
        bif.door_open = 1'b0;
        bif.floor = '0;

        // Down 4 settles on the same edge the door opens at floor 4.
        set_raw(7 + 2, 1'b1);
        for (int s = 0; s < DEB + 1; s++) step();
        bif.floor = 8'b0000_1000;
        bif.door_open = 1'b1;
        step();
        check("dn4_pulse", 9'(bif.btdn[4]), 9'd1);
        check("dn4_lamp",  9'(bif.lamp_dn[4]), 9'd0);
        bif.door_open = 1'b0;
        bif.floor = '0;
        step();
        check("dn4_lamp_after", 9'(bif.lamp_dn[4]), 9'd0);
        set_raw(7 + 2, 1'b0);
        for (int s = 0; s < DEB + 3; s++) step();

        // Reset with lamps lit and a debounce in progress.
        set_raw(1, 1'b1); set_raw(14 + 6, 1'b1);
        for (int s = 0; s < DEB + 2; s++) step();
        set_raw(1, 1'b0); set_raw(14 + 6, 1'b0);
        set_raw(14 + 2, 1'b1);
        for (int s = 0; s < 4; s++) step();
        check("pre_rst_lamps", 9'({bif.lamp_up[2], bif.lamp_car[7], bif.lamp_car[5]}), 9'd7);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_quiet("async_rst");
        step();
        rst = 1'b1;
        for (int s = 1; s <= 9; s++) begin
            step();
            check("car3_after_rst", 9'(bif.in_bt_floor[3]), 9'((s == DEB + 2) ? 1 : 0));
        end
        set_raw(14 + 2, 1'b0);
        for (int s = 0; s < DEB + 3; s++) step();

        // Randomized traffic against the model, with one reset mid-run.
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NB; k++) begin
                if ($urandom_range(0, 9) == 0) set_raw(k, ~raw_bit(k));
            end
            if ($urandom_range(0, 4) == 0) bif.floor = floor_t'($urandom_range(0, 255));
            else                           bif.floor = floor_t'(8'd1 << $urandom_range(0, 7));
            bif.door_open = ($urandom_range(0, 3) == 0);
            if (c == 400) begin
                #2;
                rst = 1'b0;
                model_reset();
                #1;
                check_quiet("rand_rst");
                step();
                rst = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_elevator_button_conditioner

// File: doc/elevator_button_conditioner.md
ELEVATOR_BUTTON_CONDITIONER -- requirements
Module: elevator_button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive clocks a synchronized input must differ from its debounced state before that state changes (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single system clock, all state on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port btup_raw  input  [7:1]  raw hall up-call buttons, floors 1..7, asynchronous to clk.
REQ-005 SHALL have port btdn_raw  input  [8:2]  raw hall down-call buttons, floors 2..8, asynchronous.
REQ-006 SHALL have port in_bt_floor_raw  input  [8:1]  raw in-car floor buttons, asynchronous.
REQ-007 SHALL have port floor  input  [8:1]  one-hot current floor from the elevator controller.
REQ-008 SHALL have port door_open  input  1  controller door-open indication (high while stopped with door open).
REQ-009 SHALL have port btup  output  [7:1]  one-cycle up-call press pulses to the controller.
REQ-010 SHALL have port btdn  output  [8:2]  one-cycle down-call press pulses to the controller.
REQ-011 SHALL have port in_bt_floor  output  [8:1]  one-cycle in-car press pulses to the controller.
REQ-012 SHALL have ports lamp_up [7:1], lamp_dn [8:2], lamp_car [8:1], all outputs, latched call-acknowledge lamps.

Function
REQ-013 Each of the 22 button inputs SHALL pass through a 2-flop synchronizer; only the second flop output (sync) feeds logic.
REQ-014 Per button, a counter SHALL reset to 0 on any clock where sync equals the debounced state, and increment otherwise.
REQ-015 When sync differs and counter equals DEBOUNCE_CYCLES-1, the debounced state SHALL take sync and the counter SHALL return to 0 on that edge.
REQ-016 A press pulse SHALL be high for exactly one cycle, registered, asserted on the edge where debounced state goes 0->1; release (1->0) SHALL produce no pulse.
REQ-017 Latency: raw input high before edge N, held high -> pulse high in the cycle following edge N+DEBOUNCE_CYCLES+1.
REQ-018 A raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no state change.
REQ-019 A held button SHALL produce one pulse only; a new pulse requires debounced release then re-press.
REQ-020 A lamp bit SHALL set on the edge its press pulse is generated and stay set until cleared.
REQ-021 When door_open=1, lamp_up, lamp_dn and lamp_car bits at the position of the set floor bit SHALL clear on that edge.
REQ-022 Simultaneous set and clear of the same lamp bit SHALL result in clear (lamp 0); the press pulse SHALL still be emitted.
REQ-023 floor not one-hot (zero or multi-hot) SHALL clear every lamp whose bit is set in floor while door_open=1; no other effect.
REQ-024 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); no wrap-around is possible since the counter resets at DEBOUNCE_CYCLES-1.

Reset
REQ-025 On rst=0, synchronizer flops, debounced states, counters, all press pulses and all lamps SHALL go to 0 immediately.
REQ-026 Reset mid-debounce or with lamps lit SHALL discard all progress; a button held through reset release SHALL produce one pulse after the REQ-017 latency measured from the first edge after release.

Structure
REQ-027 Shared package elevator_pkg SHALL hold NUM_FLOORS=8, the default DEBOUNCE_CYCLES, and one-hot floor typedef floor_t [8:1].
REQ-028 One sub-module, button_debounce (synchronizer + counter + debounced state + pulse), SHALL be instantiated 22 times; lamp logic stays in the top.

Verification
REQ-029 in_bt_floor_raw[5] high from edge 10, held -> in_bt_floor[5] pulse for one cycle after edge 15, lamp_car[5]=1 thereafter, no second pulse.
REQ-030 btup_raw[3] high for 3 clocks only -> btup all-zero, lamp_up=0.
REQ-031 lamp_dn[6]=1, floor=8'b0010_0000, door_open=1 -> lamp_dn[6]=0 next edge; lamp_up[6], lamp_car[6] also 0.
REQ-032 btdn_raw[4] debounce completes on same edge as floor=8'b0000_1000, door_open=1 -> btdn[4] pulses, lamp_dn[4] stays 0.
REQ-033 rst=0 asserted with 3 lamps lit and a debounce at count 2 -> all outputs 0 at once; raw still held -> single pulse 6 edges after reset release.
